// File: rtl/key_search_pkg.sv
// key_search_pkg: shared key width and FSM encoding for key_search_controller.
package key_search_pkg;

  localparam int KEY_W = 24;

  localparam logic [2:0] ST_IDLE        = 3'd0;
  localparam logic [2:0] ST_REQ_KEY     = 3'd1;
  localparam logic [2:0] ST_WAIT_KEY    = 3'd2;
  localparam logic [2:0] ST_START_CRACK = 3'd3;
  localparam logic [2:0] ST_WAIT_CRACK  = 3'd4;
  localparam logic [2:0] ST_FOUND       = 3'd5;
  localparam logic [2:0] ST_FAILED      = 3'd6;

  typedef enum logic [2:0] {
    IDLE        = ST_IDLE,
    REQ_KEY     = ST_REQ_KEY,
    WAIT_KEY    = ST_WAIT_KEY,
    START_CRACK = ST_START_CRACK,
    WAIT_CRACK  = ST_WAIT_CRACK,
    FOUND       = ST_FOUND,
    FAILED      = ST_FAILED
  } state_t;

endpackage

// File: rtl/key_search_controller_if.sv
// Handshake bundle between the search controller, the key generator and the decrypt core.
interface key_search_controller_if #(
  parameter int KEY_W = key_search_pkg::KEY_W
);
  logic             key_req;
  logic             key_valid;
  logic             key_last;
  logic [KEY_W-1:0] key_in;
  logic             crack_start;
  logic [KEY_W-1:0] crack_key;
  logic             crack_done;
  logic             crack_ok;

  modport master (
    output key_req, crack_start, crack_key,
    input  key_valid, key_last, key_in, crack_done, crack_ok
  );

  modport slave (
    input  key_req, crack_start, crack_key,
    output key_valid, key_last, key_in, crack_done, crack_ok
  );
endinterface

// File: rtl/key_search_watchdog.sv
// key_search_watchdog: load/count/expire counter guarding the wait for crack_done.
module key_search_watchdog #(
  parameter int LIMIT = 4096
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_load,
  input  logic i_count,
  output logic o_expire
);
  localparam int         W    = (LIMIT > 2) ? $clog2(LIMIT) : 1;
  localparam logic [W-1:0] LAST = W'(LIMIT - 2);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= '0;
    end else if (i_count) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Fires on the cycle whose increment would make the count reach LIMIT-1.
  assign o_expire = i_count & (r_cnt == LAST);

endmodule

// File: rtl/key_search_controller.sv
// key_search_controller: requests keys, runs each through the decrypt core until FOUND or FAILED.
// Define KEY_SEARCH_TIMEOUT_EN to add the crack_done watchdog and the timeout output.
module key_search_controller
  import key_search_pkg::*;
#(
  parameter int KEY_W       = key_search_pkg::KEY_W,
  parameter int CNT_W       = 25,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    go,
  input  logic                    abort,
  key_search_controller_if.master bus,
  output logic                    busy,
  output logic                    done,
  output logic                    found,
  output logic [KEY_W-1:0]        found_key,
  output logic [CNT_W-1:0]        attempt_count
`ifdef KEY_SEARCH_TIMEOUT_EN
  ,
  output logic                    timeout
`endif
);

  state_t             r_state;
  logic               r_last;
  logic [KEY_W-1:0]   r_crack_key;
  logic [KEY_W-1:0]   r_found_key;
  logic [CNT_W-1:0]   r_attempts;
  logic               w_key_seen;
  logic               w_expire;

  assign w_key_seen = bus.key_valid | bus.key_last;

`ifdef KEY_SEARCH_TIMEOUT_EN
  logic r_timeout;
  logic w_wd_load;
  logic w_wd_count;

  assign w_wd_load  = (r_state == START_CRACK);
  assign w_wd_count = (r_state == WAIT_CRACK) & ~bus.crack_done;

  key_search_watchdog #(
    .LIMIT (TIMEOUT_CYC)
  ) u_watchdog (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_load   (w_wd_load),
    .i_count  (w_wd_count),
    .o_expire (w_expire)
  );

  assign timeout = r_timeout;
`else
  logic w_unused_timeout_cfg;
  assign w_unused_timeout_cfg = (TIMEOUT_CYC > 0);
  assign w_expire             = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_last      <= 1'b0;
      r_crack_key <= '0;
      r_found_key <= '0;
      r_attempts  <= '0;
`ifdef KEY_SEARCH_TIMEOUT_EN
      r_timeout   <= 1'b0;
`endif
    end else if (abort) begin
      // Counter and found_key are deliberately left untouched on abort.
      r_state <= IDLE;
`ifdef KEY_SEARCH_TIMEOUT_EN
      r_timeout <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE, FOUND, FAILED: begin
          if (go) begin
            r_state     <= REQ_KEY;
            r_attempts  <= '0;
            r_found_key <= '0;
`ifdef KEY_SEARCH_TIMEOUT_EN
            r_timeout   <= 1'b0;
`endif
          end
        end
        REQ_KEY: r_state <= WAIT_KEY;
        WAIT_KEY: begin
          if (w_key_seen) begin
            r_crack_key <= bus.key_in;
            r_last      <= bus.key_last;
            r_state     <= START_CRACK;
          end
        end
        START_CRACK: r_state <= WAIT_CRACK;
        WAIT_CRACK: begin
          if (bus.crack_done) begin
            if (r_attempts != '1) r_attempts <= r_attempts + 1'b1;
            if (bus.crack_ok) begin
              r_state     <= FOUND;
              r_found_key <= r_crack_key;
            end else if (r_last) begin
              r_state <= FAILED;
            end else begin
              r_state <= REQ_KEY;
            end
          end else if (w_expire) begin
            r_state <= FAILED;
`ifdef KEY_SEARCH_TIMEOUT_EN
            r_timeout <= 1'b1;
`endif
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.key_req     = (r_state == REQ_KEY);
  assign bus.crack_start = (r_state == START_CRACK);
  assign bus.crack_key   = r_crack_key;
  assign busy            = (r_state == REQ_KEY) | (r_state == WAIT_KEY) |
                           (r_state == START_CRACK) | (r_state == WAIT_CRACK);
  assign done            = (r_state == FOUND) | (r_state == FAILED);
  assign found           = (r_state == FOUND);
  assign found_key       = r_found_key;
  assign attempt_count   = r_attempts;

endmodule

// File: tb/tb_key_search_controller.sv
// Self-checking bench for key_search_controller; plays key generator and decrypt core.
module tb_key_search_controller;

  localparam int KW   = 24;
  localparam int CW   = 25;
  localparam int MAXW = 100;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          go = 1'b0;
  logic          abort = 1'b0;
  logic          busy, done, found;
  logic [KW-1:0] found_key;
  logic [CW-1:0] attempt_count;
`ifdef KEY_SEARCH_TIMEOUT_EN
  logic          timeout;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int n_req   = 0;
  int n_cs    = 0;

  logic [KW-1:0] exp_key_q[$];

  key_search_controller_if #(.KEY_W(KW)) bus();

  always #5 clk = ~clk;

  key_search_controller #(
    .KEY_W       (KW),
    .CNT_W       (CW),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .go            (go),
    .abort         (abort),
    .bus           (bus),
    .busy          (busy),
    .done          (done),
    .found         (found),
    .found_key     (found_key),
    .attempt_count (attempt_count)
`ifdef KEY_SEARCH_TIMEOUT_EN
    ,
    .timeout       (timeout)
`endif
  );

  always @(posedge clk) begin
    if (bus.key_req === 1'b1) n_req <= n_req + 1;
    if (bus.crack_start === 1'b1) n_cs <= n_cs + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_go();
    go = 1'b1;
    tick();
    go = 1'b0;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < MAXW; i++) begin
      @(negedge clk);
      if (bus.key_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    tick();
  endtask

  task automatic give_key(input logic [KW-1:0] k, input logic v, input logic l);
    bus.key_in    = k;
    bus.key_valid = v;
    bus.key_last  = l;
    exp_key_q.push_back(k);
    tick();
    bus.key_valid = 1'b0;
    bus.key_last  = 1'b0;
  endtask

  task automatic wait_cs(output bit ok, output logic [KW-1:0] ck);
    ok = 1'b0;
    ck = '0;
    for (int i = 0; i < MAXW; i++) begin
      @(negedge clk);
      if (bus.crack_start === 1'b1) begin
        ok = 1'b1;
        ck = bus.crack_key;
        break;
      end
    end
    tick();
  endtask

  task automatic finish_crack(input logic ok_bit);
    bus.crack_done = 1'b1;
    bus.crack_ok   = ok_bit;
    tick();
    bus.crack_done = 1'b0;
    bus.crack_ok   = 1'b0;
  endtask

  task automatic serve(input logic [KW-1:0] k, input logic v, input logic l, input logic ok_bit,
                       output bit seen, output logic [KW-1:0] ck);
    bit r_ok, c_ok;
    wait_req(r_ok);
    give_key(k, v, l);
    wait_cs(c_ok, ck);
    finish_crack(ok_bit);
    seen = r_ok & c_ok;
  endtask

  task automatic test_reset();
    logic [KW-1:0] exp;
    reset_n = 1'b0;
    tick();
    tick();
    @(negedge clk);
    n_tests++;
    if ({busy, done, found, bus.key_req, bus.crack_start, bus.crack_key, found_key, attempt_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b done=%b found=%b key_req=%b crack_start=%b crack_key=%h found_key=%h cnt=%0d, required all 0",
               busy, done, found, bus.key_req, bus.crack_start, bus.crack_key, found_key, attempt_count);
    end
    tick();
    reset_n = 1'b1;
    tick();
    @(negedge clk);
    n_tests++;
    if ({busy, done, bus.key_req} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_release_idle: busy=%b done=%b key_req=%b, required 0 0 0", busy, done, bus.key_req);
    end
    tick();
    exp = '0;
    exp_key_q.delete();
    if (exp !== '0) exp_key_q.delete();
  endtask

  task automatic test_found();
    bit seen;
    logic [KW-1:0] ck, exp;
    int base;
    base = n_req;
    pulse_go();
    for (int k = 0; k < 2; k++) begin
      serve(KW'(k), 1'b1, 1'b0, (k == 1), seen, ck);
      exp = exp_key_q.pop_front();
      n_tests++;
      if (!seen || ck !== exp) begin
        n_fail++;
        $display("FAIL found_key%0d: seen=%b crack_key=%h, required seen=1 crack_key=%h", k, seen, ck, exp);
      end
    end
    @(negedge clk);
    n_tests++;
    if ({done, found, busy, found_key, attempt_count} !== {1'b1, 1'b1, 1'b0, 24'h000001, 25'd2}) begin
      n_fail++;
      $display("FAIL found_result: done=%b found=%b busy=%b found_key=%h cnt=%0d, required 1 1 0 000001 2",
               done, found, busy, found_key, attempt_count);
    end
    repeat (4) tick();
    @(negedge clk);
    n_tests++;
    if (n_req - base != 2 || found !== 1'b1) begin
      n_fail++;
      $display("FAIL found_req_pulses: pulses=%0d found=%b, required 2 and 1", n_req - base, found);
    end
    tick();
  endtask

  task automatic test_failed();
    bit seen;
    logic [KW-1:0] ck, exp;
    int base;
    base = n_req;
    pulse_go();
    @(negedge clk);
    n_tests++;
    if ({busy, found, found_key, attempt_count} !== {1'b1, 1'b0, 24'h0, 25'd0}) begin
      n_fail++;
      $display("FAIL failed_go_clear: busy=%b found=%b found_key=%h cnt=%0d, required 1 0 000000 0",
               busy, found, found_key, attempt_count);
    end
    // Still in REQ_KEY: the negedge sample above sits inside the request cycle.
    for (int k = 0; k < 3; k++) begin
      bit r_ok, c_ok;
      if (k == 0) begin
        r_ok = 1'b1;
        tick();
      end else begin
        wait_req(r_ok);
      end
      give_key(KW'(k), 1'b1, (k == 2));
      wait_cs(c_ok, ck);
      finish_crack(1'b0);
      seen = r_ok & c_ok;
      exp = exp_key_q.pop_front();
      n_tests++;
      if (!seen || ck !== exp) begin
        n_fail++;
        $display("FAIL failed_key%0d: seen=%b crack_key=%h, required seen=1 crack_key=%h", k, seen, ck, exp);
      end
    end
    @(negedge clk);
    n_tests++;
    if ({done, found, busy, attempt_count} !== {1'b1, 1'b0, 1'b0, 25'd3}) begin
      n_fail++;
      $display("FAIL failed_result: done=%b found=%b busy=%b cnt=%0d, required 1 0 0 3", done, found, busy, attempt_count);
    end
    repeat (5) tick();
    @(negedge clk);
    n_tests++;
    if (n_req - base != 3) begin
      n_fail++;
      $display("FAIL failed_req_pulses: pulses=%0d, required 3", n_req - base);
    end
    tick();
  endtask

  task automatic test_abort();
    bit r_ok;
    int base_req, base_cs;
    go    = 1'b1;
    abort = 1'b1;
    tick();
    go    = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({busy, done, attempt_count} !== {1'b0, 1'b0, 25'd3}) begin
      n_fail++;
      $display("FAIL abort_wins_go: busy=%b done=%b cnt=%0d, required 0 0 3", busy, done, attempt_count);
    end
    tick();
    pulse_go();
    wait_req(r_ok);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    @(negedge clk);
    n_tests++;
    if (!r_ok || {busy, done, bus.key_req} !== 3'b000) begin
      n_fail++;
      $display("FAIL abort_wait_key: req_seen=%b busy=%b done=%b key_req=%b, required 1 0 0 0", r_ok, busy, done, bus.key_req);
    end
    tick();
    base_cs       = n_cs;
    bus.key_in    = 24'h000007;
    bus.key_valid = 1'b1;
    tick();
    bus.key_valid = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    n_tests++;
    if (n_cs != base_cs || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_key_ignored: crack_starts=%0d busy=%b, required 0 and 0", n_cs - base_cs, busy);
    end
    tick();
    base_req = n_req;
    pulse_go();
    repeat (8) tick();
    @(negedge clk);
    n_tests++;
    if (n_req - base_req != 1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_rego_one_req: pulses=%0d busy=%b, required 1 and 1", n_req - base_req, busy);
    end
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic test_both_flags();
    bit seen;
    logic [KW-1:0] ck, exp;
    pulse_go();
    serve(24'hFFFFFF, 1'b1, 1'b1, 1'b0, seen, ck);
    exp = exp_key_q.pop_front();
    n_tests++;
    if (!seen || ck !== exp) begin
      n_fail++;
      $display("FAIL both_flags_key: seen=%b crack_key=%h, required seen=1 crack_key=%h", seen, ck, exp);
    end
    @(negedge clk);
    n_tests++;
    if ({done, found, busy, attempt_count} !== {1'b1, 1'b0, 1'b0, 25'd1}) begin
      n_fail++;
      $display("FAIL both_flags_result: done=%b found=%b busy=%b cnt=%0d, required 1 0 0 1", done, found, busy, attempt_count);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    bit seen, r_ok, c_ok;
    logic [KW-1:0] ck, exp;
    int base_req, base_cs;
    pulse_go();
    serve(24'h000003, 1'b1, 1'b0, 1'b0, seen, ck);
    exp = exp_key_q.pop_front();
    wait_req(r_ok);
    give_key(24'h000004, 1'b1, 1'b0);
    wait_cs(c_ok, ck);
    exp = exp_key_q.pop_front();
    n_tests++;
    if (!(seen && r_ok && c_ok) || ck !== exp || attempt_count !== 25'd1) begin
      n_fail++;
      $display("FAIL rstmid_setup: seen=%b crack_key=%h cnt=%0d, required seen=1 crack_key=%h cnt=1", seen & r_ok & c_ok, ck, attempt_count, exp);
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_tests++;
    if ({busy, done, found, bus.key_req, bus.crack_start, bus.crack_key, attempt_count} !== '0) begin
      n_fail++;
      $display("FAIL rstmid_async: busy=%b done=%b key_req=%b crack_start=%b crack_key=%h cnt=%0d, required all 0",
               busy, done, bus.key_req, bus.crack_start, bus.crack_key, attempt_count);
    end
    tick();
    reset_n = 1'b1;
    base_req = n_req;
    base_cs  = n_cs;
    finish_crack(1'b0);
    repeat (5) tick();
    @(negedge clk);
    n_tests++;
    if (n_req != base_req || n_cs != base_cs || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_no_pulses: key_req=%0d crack_start=%0d busy=%b, required 0 0 0", n_req - base_req, n_cs - base_cs, busy);
    end
    tick();
  endtask

`ifdef KEY_SEARCH_TIMEOUT_EN
  task automatic test_timeout();
    bit r_ok, c_ok;
    logic [KW-1:0] ck, exp;
    pulse_go();
    wait_req(r_ok);
    give_key(24'h000009, 1'b1, 1'b0);
    wait_cs(c_ok, ck);
    exp = exp_key_q.pop_front();
    n_tests++;
    if (!(r_ok && c_ok) || ck !== exp) begin
      n_fail++;
      $display("FAIL timeout_key: seen=%b crack_key=%h, required seen=1 crack_key=%h", r_ok & c_ok, ck, exp);
    end
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 15) begin
        n_tests++;
        if ({done, busy, timeout} !== 3'b010) begin
          n_fail++;
          $display("FAIL timeout_early: done=%b busy=%b timeout=%b, required 0 1 0", done, busy, timeout);
        end
      end
      if (k == 16) begin
        n_tests++;
        if ({done, found, timeout} !== 3'b101) begin
          n_fail++;
          $display("FAIL timeout_fire: done=%b found=%b timeout=%b, required 1 0 1", done, found, timeout);
        end
      end
    end
    tick();
    pulse_go();
    @(negedge clk);
    n_tests++;
    if (timeout !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_clear: timeout=%b busy=%b, required 0 1", timeout, busy);
    end
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask
`endif

  initial begin
    bus.key_valid  = 1'b0;
    bus.key_last   = 1'b0;
    bus.key_in     = '0;
    bus.crack_done = 1'b0;
    bus.crack_ok   = 1'b0;
    test_reset();
    test_found();
    test_failed();
    test_abort();
    test_both_flags();
    test_reset_mid();
`ifdef KEY_SEARCH_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_watchdog: simulation time limit reached, required completion");
    $fatal(1, "bench time limit");
  end

endmodule
